pwm_peripheral: RTL and testbench

//   Consumes the register file written by the SPI peripheral.

---
 rtl/pwm_peripheral.sv | 117 +++++++++++
 tb/tb_pwm_peripheral.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//   Drives 16 output pins from the register file written by the SPI block.
//   Each pin is either forced low, driven static high, or PWM-modulated by a
//   single shared 8-bit duty value. The duty value is captured into a shadow
//   register only at the PWM period boundary, so a mid-period write never
//   shortens or stretches the pulse in flight.
//
// Parameters
//   CLK_DIV          clk cycles per PWM counter step (>=1);
//                    one PWM period = 256*CLK_DIV clk cycles
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous, active-high reset
//   en_reg_out_7_0   output enable, pins 7..0
//   en_reg_out_15_8  output enable, pins 15..8
//   en_reg_pwm_7_0   PWM select, pins 7..0 (1 = PWM, 0 = static high)
//   en_reg_pwm_15_8  PWM select, pins 15..8
//   pwm_duty_cycle   requested duty, 0..255
//   out              registered pin drive, bit i = pin i
//   period_start     one-cycle pulse on the edge where the counter wraps
// -----------------------------------------------------------------------------
module pwm_peripheral #(
   parameter int CLK_DIV = 3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [7:0]         pwm_cnt_q, pwm_cnt_d;
   logic [7:0]         duty_shadow_q, duty_shadow_d;
   logic [15:0]        out_q, out_d;
   logic               period_start_q, period_start_d;

   logic               tick_s;
   logic               wrap_s;
   logic               pwm_raw_s;
   logic [15:0]        en_out_s;
   logic [15:0]        en_pwm_s;

   // Next-state logic: prescaler, step counter, duty shadow and pin drive.
   always_comb begin
      en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};

      // With CLK_DIV=1 PRESC_LAST is 0 and presc never leaves 0, so tick is constant 1.
      tick_s = (presc_q == PRESC_LAST);
      wrap_s = tick_s && (pwm_cnt_q == 8'hFF);

      if (tick_s) begin
         presc_d   = '0;
         pwm_cnt_d = pwm_cnt_q + 8'd1;   // 255 -> 0 by natural 8-bit wrap
      end else begin
         presc_d   = presc_q + PRESC_W'(1);
         pwm_cnt_d = pwm_cnt_q;
      end

      if (wrap_s) begin
         duty_shadow_d = pwm_duty_cycle;
      end else begin
         duty_shadow_d = duty_shadow_q;
      end

      period_start_d = wrap_s;

      // Duty 255 is special-cased so the pin never drops for the final step.
      if (duty_shadow_q == 8'hFF) begin
         pwm_raw_s = 1'b1;
      end else begin
         pwm_raw_s = (pwm_cnt_q < duty_shadow_q);
      end

      out_d = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         if (!en_out_s[i]) begin
            out_d[i] = 1'b0;
         end else if (en_pwm_s[i]) begin
            out_d[i] = pwm_raw_s;
         end else begin
            out_d[i] = 1'b1;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q        <= '0;
         pwm_cnt_q      <= 8'd0;
         duty_shadow_q  <= 8'd0;
         out_q          <= 16'h0000;
         period_start_q <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         pwm_cnt_q      <= pwm_cnt_d;
         duty_shadow_q  <= duty_shadow_d;
         out_q          <= out_d;
         period_start_q <= period_start_d;
      end
   end

   assign out          = out_q;
   assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//   Scoreboard bench for pwm_peripheral with CLK_DIV=2 (period 512 clks).
//   The reference model works from elapsed time: it counts clean edges since
//   the last reset, derives the counter step and period boundaries from that
//   count by division, and remembers the duty sampled at the latest boundary.
//   The driver pushes the expected post-edge outputs into a queue; a monitor
//   pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

   localparam int D = 2;
   localparam int P = 256 * D;

   logic        clk;
   logic        rst;
   logic [15:0] en_out;
   logic [15:0] en_pwm;
   logic [7:0]  duty;
   logic [15:0] out;
   logic        period_start;

   pwm_peripheral #(.CLK_DIV(D)) dut (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (en_out[7:0]),
      .en_reg_out_15_8 (en_out[15:8]),
      .en_reg_pwm_7_0  (en_pwm[7:0]),
      .en_reg_pwm_15_8 (en_pwm[15:8]),
      .pwm_duty_cycle  (duty),
      .out             (out),
      .period_start    (period_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {period_start, out} after each rising edge.
   logic [16:0] exp_q[$];
   int          tests = 0;
   int          fails = 0;

   // Reference model state.
   int          n = 0;          // clean edges since last reset
   logic [7:0]  m_shadow = 8'd0;

   // Apply one rising edge to the model using the inputs currently driven,
   // then queue the expected outputs for the monitor.
   task automatic edge_step();
      logic [15:0] e_out;
      logic        e_ps;
      int          step;
      logic        high;
      if (rst) begin
         n     = 0;
         m_shadow = 8'd0;
         e_out = 16'h0000;
         e_ps  = 1'b0;
      end else begin
         step = (n / D) % 256;
         if (m_shadow == 8'd255) high = 1'b1;
         else high = (step < int'(m_shadow));
         for (int i = 0; i < 16; i++) begin
            if (!en_out[i]) e_out[i] = 1'b0;
            else if (en_pwm[i]) e_out[i] = high;
            else e_out[i] = 1'b1;
         end
         n    = n + 1;
         e_ps = ((n % P) == 0);
         if (e_ps) m_shadow = duty;
      end
      @(posedge clk);
      exp_q.push_back({e_ps, e_out});
      #1;
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) edge_step();
   endtask

   // Advance at least one edge, stopping when the period phase reaches ph.
   task automatic run_until(input int ph);
      int guard;
      guard = 0;
      edge_step();
      while ((n % P) != ph && guard < 2 * P) begin
         edge_step();
         guard++;
      end
      tests++;
      if ((n % P) != ph) begin
         fails++;
         $display("FAIL run_until: phase %0d required %0d", n % P, ph);
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectations.
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (out !== e[15:0]) begin
               fails++;
               $display("FAIL out @%0t: got %h required %h", $time, out, e[15:0]);
            end
            tests++;
            if (period_start !== e[16]) begin
               fails++;
               $display("FAIL period_start @%0t: got %b required %b", $time, period_start, e[16]);
            end
         end
      end
   end

   initial begin
      int len;
      rst    = 1'b1;
      en_out = 16'hFFFF;
      en_pwm = 16'hFFFF;
      duty   = 8'hFF;

      // Reset held with all inputs high.
      run(3);

      // Single static-high pin.
      rst    = 1'b0;
      en_out = 16'h0001;
      en_pwm = 16'h0000;
      duty   = 8'd0;
      run(20);

      // All pins PWM at duty 64: first period low, then 128 high / 384 low.
      en_out = 16'hFFFF;
      en_pwm = 16'hFFFF;
      duty   = 8'd64;
      run(3 * P);

      // Full-on and full-off duty.
      duty = 8'd255;
      run(2 * P);
      duty = 8'd0;
      run(2 * P);

      // Mid-period duty change must wait for the boundary.
      duty = 8'd64;
      run_until(0);
      run_until(100);
      duty = 8'd192;
      run(2 * P);

      // Reset during the high phase restarts the period.
      run_until(50);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      run(P + 100);

      // Randomized register settings, durations and occasional resets.
      for (int s = 0; s < 16; s++) begin
         en_out = 16'($urandom);
         en_pwm = 16'($urandom);
         case ($urandom_range(0, 3))
            0: duty = 8'd0;
            1: duty = 8'd255;
            default: duty = 8'($urandom);
         endcase
         rst = ($urandom_range(0, 9) == 0);
         run(1);
         rst = 1'b0;
         len = $urandom_range(1, 700);
         run(len);
      end

      // Drain the scoreboard.
      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
